// File: rtl/pipeline_checkpoint_checker.sv
// pipeline_checkpoint_checker: arms on start, triggers on cycle count or PC match, then checks registers one per cycle
module pipeline_checkpoint_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [CNT_W-1:0]          target_cycle,
  input  logic [DATA_W-1:0]         target_pc,
  input  logic [CNT_W-1:0]          timeout_lim,
  input  logic [DATA_W-1:0]         pc_in,
  input  logic [NUM_CHK-1:0]        chk_en,
  input  logic [NUM_CHK*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHK*DATA_W-1:0] chk_exp,
  output logic [ADDR_W-1:0]         rf_raddr,
  input  logic [DATA_W-1:0]         rf_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [NUM_CHK-1:0]        fail_mask,
  output logic                      timeout,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [DATA_W-1:0]         trig_pc
);
  localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t                    state;
  logic                      mode_q;
  logic [CNT_W-1:0]          tcyc_q, tlim_q;
  logic [DATA_W-1:0]         tpc_q;
  logic [NUM_CHK-1:0]        en_q;
  logic [NUM_CHK*ADDR_W-1:0] addr_q;
  logic [NUM_CHK*DATA_W-1:0] exp_q;
  logic [IDX_W-1:0]          idx;
  logic                      trig, last;
  logic [NUM_CHK-1:0]        fm_nxt;
  always_comb begin
    trig = mode_q ? (pc_in == tpc_q) : (cycle_count == tcyc_q || tcyc_q == '0);
    last = idx == IDX_W'(NUM_CHK - 1);
    fm_nxt = fail_mask;
    fm_nxt[idx] = en_q[idx] & (rf_rdata != exp_q[idx*DATA_W +: DATA_W]);
    rf_raddr = (state == CHECK) ? addr_q[idx*ADDR_W +: ADDR_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_mask   <= '0;
      cycle_count <= '0;
      trig_pc     <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mode_q      <= mode;
          tcyc_q      <= target_cycle;
          tpc_q       <= target_pc;
          tlim_q      <= timeout_lim;
          en_q        <= chk_en;
          addr_q      <= chk_addr;
          exp_q       <= chk_exp;
          cycle_count <= CNT_W'(1);
          pass        <= 1'b0;
          fail_mask   <= '0;
          timeout     <= 1'b0;
          trig_pc     <= '0;
          busy        <= 1'b1;
          done        <= 1'b0;
          state       <= RUN;
        end
        RUN: if (trig) begin
          trig_pc <= pc_in;
          idx     <= '0;
          state   <= CHECK;
        end else if (mode_q && cycle_count == tlim_q) begin
          timeout <= 1'b1;
          pass    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
        end else begin
          cycle_count <= &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
        end
        CHECK: begin
          fail_mask <= fm_nxt;
          idx       <= idx + IDX_W'(1);
          if (last) begin
            pass  <= fm_nxt == '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_checkpoint_checker.sv
// tb_pipeline_checkpoint_checker: directed checks of trigger modes, register checks, timeout, reset and restart
module tb_pipeline_checkpoint_checker;
  logic        clk = 0, rst = 1, start = 0, mode = 0;
  logic [31:0] target_cycle = 0, target_pc = 0, timeout_lim = 0, pc_in = 0;
  logic [3:0]  chk_en = 4'b0111;
  logic [19:0] chk_addr = {5'd22, 5'd21, 5'd20, 5'd19};
  logic [127:0] chk_exp = {32'd77, 32'd15, 32'd10, 32'd0};
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy, done, pass, timeout;
  logic [3:0]  fail_mask;
  logic [31:0] cycle_count, trig_pc;
  logic [31:0] rf [32];
  int n_chk = 0, n_fail = 0, n = 0;
  logic raddr_nz = 0;
  pipeline_checkpoint_checker dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .target_cycle(target_cycle),
    .target_pc(target_pc), .timeout_lim(timeout_lim), .pc_in(pc_in), .chk_en(chk_en),
    .chk_addr(chk_addr), .chk_exp(chk_exp), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .timeout(timeout),
    .cycle_count(cycle_count), .trig_pc(trig_pc)
  );
  assign rf_rdata = rf[rf_raddr];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    pc_in = 396 + 4 * n;
    if (rf_raddr != 0) raddr_nz = 1;
  endtask
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  task automatic arm(input logic m, input logic [31:0] tc, input logic [31:0] tpc, input logic [31:0] tl);
    mode = m; target_cycle = tc; target_pc = tpc; timeout_lim = tl;
    start = 1; n = 0; raddr_nz = 0;
    tick();
    start = 0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hdead0000 + i;
    rf[19] = 0; rf[20] = 10; rf[21] = 15; rf[22] = 0;
    ticks(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_outs", {timeout, fail_mask, cycle_count, trig_pc, rf_raddr}, 0);
    rst = 0;
    // T1: cycle trigger at 13, all enabled registers match
    arm(0, 13, 0, 0);
    chk("t1_busy", busy, 1);
    ticks(16);
    chk("t1_not_done_17", done, 0);
    tick();
    chk("t1_done_18", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_mask", fail_mask, 4'b0000);
    chk("t1_cnt", cycle_count, 13);
    chk("t1_trig_pc", trig_pc, 448);
    chk("t1_busy_off", busy, 0);
    // T2: channel 1 mismatches
    rf[20] = 9;
    arm(0, 13, 0, 0);
    chk("t2_cnt_restart", cycle_count, 1);
    chk("t2_done_clr", done, 0);
    ticks(17);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_mask", fail_mask, 4'b0010);
    chk("t2_trig_pc", trig_pc, 448);
    // T3: PC trigger at cycle 6, restart clears prior mask
    rf[20] = 10;
    arm(1, 0, 420, 50);
    chk("t6_mask_clr", fail_mask, 0);
    chk("t6_trig_clr", trig_pc, 0);
    ticks(9);
    chk("t3_not_done", done, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_trig_pc", trig_pc, 420);
    chk("t3_cnt", cycle_count, 6);
    chk("t3_timeout", timeout, 0);
    chk("t3_pass", pass, 1);
    // trigger and timeout on the same cycle: trigger wins
    arm(1, 0, 420, 6);
    ticks(10);
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_trig_pc", trig_pc, 420);
    // T4: PC never reached, timeout at 20
    arm(1, 0, 4, 20);
    ticks(19);
    chk("t4_not_done", done, 0);
    tick();
    chk("t4_done", done, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_pass", pass, 0);
    chk("t4_mask", fail_mask, 0);
    chk("t4_cnt", cycle_count, 20);
    chk("t4_no_reads", raddr_nz, 0);
    // T6: restart after timeout, target_cycle 0, all channels disabled
    rf[20] = 9; chk_en = 4'b0000;
    arm(0, 0, 0, 0);
    chk("t6_timeout_clr", timeout, 0);
    chk("t6_cnt", cycle_count, 1);
    ticks(4);
    chk("tc0_not_done", done, 0);
    tick();
    chk("tc0_done", done, 1);
    chk("tc0_pass", pass, 1);
    chk("tc0_trig_pc", trig_pc, 400);
    // T5: start ignored while busy, reset mid-CHECK
    chk_en = 4'b0111;
    arm(0, 13, 0, 0);
    ticks(4);
    start = 1; target_cycle = 3;
    tick();
    start = 0;
    chk("t5_start_ign", cycle_count, 6);
    ticks(10);
    chk("t5_idx2_addr", rf_raddr, 21);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_rst_state", {busy, done, pass, timeout}, 0);
    chk("t5_rst_outs", {fail_mask, cycle_count, trig_pc, rf_raddr}, 0);
    ticks(3);
    chk("t5_idle_stays", {busy, done, cycle_count}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
